// File: rtl/gtech_barrier8_ctrl.sv
// gtech_barrier8_ctrl
//   Eight-requester barrier. A sequencing master arms it with a participant
//   mask and a wait-cycle budget; workers strobe arrive. Once every
//   participant has arrived, a one-cycle release pulse is issued. If the
//   budget runs out first, a one-cycle tmo pulse is issued and the
//   participants that never showed up are reported on missing.
//
// Ports
//   clk, rst_n     rising-edge clock, async active-low reset
//   start          arm request (accepted in IDLE only)
//   mask[7:0]      participating requesters, sampled on accepted start
//   timeout[TO_W]  wait budget in cycles, sampled on accepted start, 0 = none
//   arrive[7:0]    per-requester arrival strobes, level-sampled
//   busy           high outside IDLE
//   arrived[7:0]   latched arrivals of the current/last barrier
//   release_pulse  barrier complete, one cycle
//                  ("release" itself is a reserved word)
//   tmo            barrier timed out, one cycle
//   missing[7:0]   participants absent at timeout, held until next start

// Per-requester slice: folds a new arrival into the latched set and reports
// whether this requester is satisfied (arrived, or not participating).
module gtech_barrier8_lane (
  input  logic arrive,
  input  logic mask,
  input  logic arrived,
  output logic arr_next,
  output logic done
);
  assign arr_next = arrived | (arrive & mask);
  assign done     = arr_next | ~mask;
endmodule

module gtech_barrier8_ctrl #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      mask,
  input  logic [TO_W-1:0] timeout,
  input  logic [7:0]      arrive,
  output logic            busy,
  output logic [7:0]      arrived,
  output logic            release_pulse,
  output logic            tmo,
  output logic [7:0]      missing
);
  localparam int NUM_REQ = 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REL, S_TOUT} state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   mask_q;
  logic [TO_W-1:0]      cnt;
  logic [NUM_REQ-1:0]   arr_next;
  logic [NUM_REQ-1:0]   done_vec;
  logic                 all_done;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    gtech_barrier8_lane u_lane (
      .arrive   (arrive[i]),
      .mask     (mask_q[i]),
      .arrived  (arrived[i]),
      .arr_next (arr_next[i]),
      .done     (done_vec[i])
    );
  end

  assign all_done = &done_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      cnt     <= '0;
      arrived <= '0;
      missing <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q  <= mask;
            cnt     <= timeout;
            arrived <= '0;
            missing <= '0;
            // An empty mask is trivially complete.
            state   <= (mask == '0) ? S_REL : S_WAIT;
          end
        end
        S_WAIT: begin
          arrived <= arr_next;
          // Completion is tested first so it wins over a same-cycle expiry.
          // cnt stops at 1 when a budget was given, so cnt==1 can only be
          // reached with a nonzero timeout; a zero budget stays parked at 0.
          if (all_done) begin
            state <= S_REL;
          end else if (cnt == TO_W'(1)) begin
            state   <= S_TOUT;
            missing <= mask_q & ~arr_next;
          end else if (cnt != '0) begin
            cnt <= cnt - TO_W'(1);
          end
        end
        S_REL:   state <= S_IDLE;
        S_TOUT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign release_pulse = (state == S_REL);
  assign tmo           = (state == S_TOUT);

endmodule

// File: tb/tb_gtech_barrier8_ctrl.sv
module tb_gtech_barrier8_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mask;
  logic [15:0] timeout;
  logic [7:0]  arrive;
  logic        busy;
  logic [7:0]  arrived;
  logic        release_pulse;
  logic        tmo;
  logic [7:0]  missing;

  int n_tests = 0;
  int n_fail  = 0;

  // Arrival schedule: arr_tbl[k] is the arrive value sampled at edge k
  // (edge 0 = accepted start).
  logic [7:0] arr_tbl [0:63];

  gtech_barrier8_ctrl #(.TO_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mask          (mask),
    .timeout       (timeout),
    .arrive        (arrive),
    .busy          (busy),
    .arrived       (arrived),
    .release_pulse (release_pulse),
    .tmo           (tmo),
    .missing       (missing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_tbl();
    for (int k = 0; k < 64; k++) arr_tbl[k] = 8'h00;
  endtask

  // Random schedule; a zero budget is guaranteed to finish by edge 40.
  task automatic fill_rand(input logic [15:0] t);
    logic [7:0] v;
    for (int k = 0; k < 64; k++) begin
      v = 8'($urandom | $urandom);
      arr_tbl[k] = ($urandom_range(0, 2) == 0) ? v : 8'h00;
    end
    if (t == 0) arr_tbl[40] = 8'hFF;
  endtask

  // Work out the outcome of one barrier from the arrival schedule, then
  // drive it and check every cycle through the first IDLE cycle afterwards.
  // Cycle c is the period following edge c-1.
  task automatic run_barrier(input logic [7:0] m, input logic [15:0] t, input string nm);
    logic [7:0] acc [0:64];
    logic [7:0] miss;
    int kend, ai, c;
    bit is_tout;
    acc[0] = 8'h00; kend = 0; is_tout = 0; miss = 8'h00;
    if (m != 0) begin
      for (int k = 1; k < 64; k++) begin
        acc[k] = acc[k-1] | (arr_tbl[k] & m);
        kend = k;
        if (acc[k] == m) break;
        if (t != 0 && k == int'(t)) begin
          is_tout = 1;
          miss = m & ~acc[k];
          break;
        end
      end
    end
    for (int e = 0; e <= kend + 1; e++) begin
      @(negedge clk);
      if (e == 0) begin
        start = 1'b1; mask = m; timeout = t;
        arrive = 8'($urandom);
      end else begin
        // Extra starts while busy must be ignored.
        start = 1'($urandom_range(0, 1));
        mask = 8'($urandom); timeout = 16'($urandom_range(0, 8));
        arrive = (e <= kend) ? arr_tbl[e] : 8'($urandom);
      end
      @(posedge clk); #1;
      c  = e + 1;
      ai = (e < kend) ? e : kend;
      chk($sformatf("%s c%0d busy", nm, c), busy, (c <= kend + 1));
      chk($sformatf("%s c%0d release", nm, c), release_pulse, (c == kend + 1) && !is_tout);
      chk($sformatf("%s c%0d tmo", nm, c), tmo, (c == kend + 1) && is_tout);
      chk($sformatf("%s c%0d arrived", nm, c), arrived, acc[ai]);
      chk($sformatf("%s c%0d missing", nm, c), missing, (c >= kend + 1 && is_tout) ? miss : 8'h00);
    end
  endtask

  initial begin
    logic [7:0]  rm;
    logic [15:0] rt;
    rst_n = 1'b0; start = 1'b0; mask = 8'h00; timeout = 16'h0; arrive = 8'h00;
    clr_tbl();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset release", release_pulse, 0);
    chk("reset tmo", tmo, 0);
    chk("reset arrived", arrived, 0);
    chk("reset missing", missing, 0);
    @(negedge clk); rst_n = 1'b1;

    // One requester per cycle, no budget: release in cycle 9.
    clr_tbl();
    for (int k = 1; k <= 8; k++) arr_tbl[k] = 8'(1 << (k - 1));
    run_barrier(8'hFF, 16'd0, "order");

    // Partial mask, stray bit outside mask, expiry after 5 cycles.
    clr_tbl();
    arr_tbl[1] = 8'h01; arr_tbl[2] = 8'h02; arr_tbl[3] = 8'h10;
    run_barrier(8'h0F, 16'd5, "tout");

    // Completion on the expiry edge wins.
    clr_tbl();
    arr_tbl[3] = 8'h03;
    run_barrier(8'h03, 16'd3, "tie");

    // Empty mask, then a barrier that absorbs stray starts while waiting.
    clr_tbl();
    run_barrier(8'h00, 16'd0, "empty");
    clr_tbl();
    arr_tbl[4] = 8'h01;
    run_barrier(8'h01, 16'd0, "busystart");

    // Fastest completion.
    clr_tbl();
    arr_tbl[1] = 8'hA5;
    run_barrier(8'hA5, 16'd7, "fast");

    // Reset in the middle of a wait.
    @(negedge clk); start = 1'b1; mask = 8'hFF; timeout = 16'd0; arrive = 8'h00;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0; arrive = 8'h3C;
    @(posedge clk); #1;
    chk("rstmid pre arrived", arrived, 8'h3C);
    chk("rstmid pre busy", busy, 1);
    @(negedge clk); arrive = 8'hFF; rst_n = 1'b0;
    #1;
    chk("rstmid busy", busy, 0);
    chk("rstmid arrived", arrived, 0);
    chk("rstmid release", release_pulse, 0);
    chk("rstmid tmo", tmo, 0);
    chk("rstmid missing", missing, 0);
    @(posedge clk); #1;
    chk("rstmid hold release", release_pulse, 0);
    chk("rstmid hold busy", busy, 0);
    @(negedge clk); rst_n = 1'b1; arrive = 8'h00;
    @(posedge clk); #1;
    chk("rstmid after release", release_pulse, 0);
    chk("rstmid after arrived", arrived, 0);
    clr_tbl();
    arr_tbl[2] = 8'h0F; arr_tbl[5] = 8'hF0;
    run_barrier(8'hFF, 16'd9, "postrst");

    // Randomized barriers, back to back.
    for (int n = 0; n < 40; n++) begin
      rm = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 9) == 0) rm = 8'h00;
      rt = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      fill_rand(rt);
      run_barrier(rm, rt, $sformatf("rnd%0d", n));
    end

    @(negedge clk); start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gtech_barrier8_ctrl.md
# gtech_barrier8_ctrl

Eight-requester barrier controller built around an 8-input AND reduction. Requesters signal arrival, and the block latches each arrival. Once every participating requester has arrived, it issues a single release pulse; if not all arrive in time, it reports a timeout together with the set of missing requesters. It sits between a sequencing master, which arms it, and up to eight worker blocks, which arrive at it.

## Interface
- TO_W, 16, width of the timeout counter and of the TIMEOUT port.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  arm request, single-cycle. Accepted only in IDLE.
- MASK  in  8  participating requesters. Sampled on the accepted START.
- TIMEOUT  in  TO_W  wait-cycle budget. Sampled on the accepted START. 0 disables the timeout.
- ARRIVE  in  8  per-requester arrival strobes. Level-sampled every cycle.
- BUSY  out  1  high in every state except IDLE.
- ARRIVED  out  8  latched arrivals of the current or last barrier.
- RELEASE  out  1  barrier complete, one-cycle pulse.
- TMO  out  1  barrier timed out, one-cycle pulse.
- MISSING  out  8  participating requesters that had not arrived at timeout. Held until the next accepted START.

## Operation
- States: IDLE, WAIT, REL, TOUT. All outputs are registered or decoded from the registered state.
- Reset: state IDLE; BUSY=0, RELEASE=0, TMO=0, ARRIVED=0, MISSING=0; internal mask and counter are 0.
- IDLE, START=1:
  - mask_q <= MASK; cnt <= TIMEOUT; ARRIVED <= 0; MISSING <= 0.
  - Next state is WAIT, or REL directly if MASK==0.
- WAIT, each cycle:
  - arr_next = ARRIVED | (ARRIVE & mask_q); ARRIVED <= arr_next.
  - done = AND over all 8 bits of (arr_next | ~mask_q).
  - If done: go to REL.
  - Else if TIMEOUT was nonzero and cnt==1: go to TOUT, with MISSING <= mask_q & ~arr_next.
  - Else: cnt <= cnt-1 (only when nonzero, so no wrap).
- REL: RELEASE=1 for exactly one cycle, then IDLE.
- TOUT: TMO=1 for exactly one cycle, then IDLE.
- Completion and expiry in the same cycle: completion wins. Go to REL; TMO stays 0 and MISSING stays 0.
- ARRIVE bits outside mask_q are ignored. ARRIVE in IDLE, REL or TOUT is ignored. Repeated arrivals from the same requester are idempotent.
- START while BUSY=1 is ignored, with no effect on the barrier in progress.
- ARRIVED and MISSING hold their values in IDLE until the next accepted START.
- RST_N low at any time, including mid-WAIT: immediate return to the reset values. No RELEASE or TMO is generated.

## Timing
- The START edge is edge 0. BUSY=1 from cycle 1.
- An arrival sampled at edge k shows in ARRIVED from cycle k+1.
- If arrival at edge k completes the barrier, RELEASE is high in cycle k+1 and BUSY drops in cycle k+2.
- Fastest case: all requesters already asserting ARRIVE at edge 1 gives RELEASE in cycle 2.
- MASK==0: RELEASE in cycle 1.
- Timeout of T≥1 with no completion: WAIT occupies edges 1..T, TMO is high in cycle T+1, and MISSING is valid from cycle T+1.
- Back-to-back barriers: a START in the first IDLE cycle after REL or TOUT is accepted.

## Test plan
- Arrival order and release: MASK=0xFF, TIMEOUT=0, ARRIVE one bit per cycle 0x01…0x80 from edge 1 → ARRIVED grows by one bit per cycle; RELEASE in cycle 9 only; TMO=0.
- Partial mask with timeout: MASK=0x0F, TIMEOUT=5, arrivals 0x01, 0x02 and stray 0x10 → TMO in cycle 6; MISSING=0x0C; ARRIVED=0x03; RELEASE never asserts.
- Completion on the expiry cycle: MASK=0x03, TIMEOUT=3, ARRIVE=0x03 at edge 3 → RELEASE in cycle 4; TMO=0; MISSING=0x00.
- Start handling: MASK=0x00 → RELEASE in cycle 1. Then START during WAIT of a MASK=0x01 barrier → ignored; the barrier completes normally on its own ARRIVE.
- Reset mid-wait: MASK=0xFF with ARRIVED=0x3C, RST_N low for 1 cycle → all outputs 0, state IDLE. A fresh START then runs a barrier normally.
